// File: rtl/uart_tx_port_if.sv
// CPU-side bus bundle for the memory-mapped UART transmitter.
// The CPU drives address/strobe/data; the responder drives read data and hit.
interface uart_tx_port_if;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        hit;

  modport master (
    output address,
    output write_en,
    output data_in,
    input  data_out,
    input  hit
  );

  modport slave (
    input  address,
    input  write_en,
    input  data_in,
    output data_out,
    output hit
  );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: bus writes feed a small FIFO that an
// 8N1 shifter drains onto txd, with a pollable status register.
module uart_tx_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF010,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_tx_port_if.slave  bus,
  output logic           txd
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [15:0]     STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             overflow;

  logic             fifo_empty;
  logic             fifo_full;
  logic             bit_done;
  logic             pop;
  logic             push;
  logic             wr_data;
  logic             wr_stat;
  logic             busy;
  logic             idle;
  logic [7:0]       head;
  logic [7:0]       status;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  assign bit_done   = (baud_cnt == LAST_CNT);
  // The shifter takes a byte from IDLE, or at the end of a stop bit so
  // consecutive frames run without an idle gap.
  assign pop        = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_done));

  assign wr_data    = bus.write_en && (bus.address == BASE_ADDR);
  assign wr_stat    = bus.write_en && (bus.address == STAT_ADDR);
  assign push       = wr_data && (!fifo_full || pop);

  assign busy       = (state != IDLE);
  assign idle       = fifo_empty && !busy;
  assign status     = {3'b000, idle, overflow, fifo_empty, fifo_full, busy};

  assign bus.hit      = (bus.address == BASE_ADDR) || (bus.address == STAT_ADDR);
  assign bus.data_out = (bus.address == STAT_ADDR) ? status : 8'h00;

  // FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
      if (wr_stat) begin
        overflow <= 1'b0;
      end else if (wr_data && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Shift register: loaded on pop, shifted right as each data bit ends.
  always_ff @(posedge clock) begin
    if (pop) begin
      shreg <= head;
    end else if ((state == DATA) && bit_done) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          txd      <= 1'b1;
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          txd      <= 1'b1;
        end
      endcase
    end
  end

endmodule
